// File: rtl/flow_mig_pkg.sv
// flow_mig_pkg: controller states, buffering modes and flow-entry field layout
package flow_mig_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SCAN    = 3'd2,
        ST_MIGRATE = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [1:0] BUF_NONE   = 2'd0;
    localparam logic [1:0] BUF_ALL    = 2'd1;
    localparam logic [1:0] BUF_STREAM = 2'd3;

    // Entry = {valid, fin, epoch, last_time, tuple}; tuple sits at the LSBs
    function automatic int entry_width(input int tup_w, input int time_w);
        return tup_w + time_w + 3;
    endfunction

    function automatic int epoch_bit(input int tup_w, input int time_w);
        return tup_w + time_w;
    endfunction

    function automatic int fin_bit(input int tup_w, input int time_w);
        return tup_w + time_w + 1;
    endfunction

    function automatic int valid_bit(input int tup_w, input int time_w);
        return tup_w + time_w + 2;
    endfunction

endpackage

// File: rtl/flow_table_ram.sv
// flow_table_ram: simple dual-port flow table, one write port, registered read port
module flow_table_ram #(
    parameter int AW = 10,
    parameter int DW = 139
)(
    input  logic          axis_aclk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // Write and read share the clock; same-address read data is not relied upon
    always_ff @(posedge axis_aclk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/flow_migration_ctrl.sv
// flow_migration_ctrl: flow table lookup and per-packet buffering decision during migration
module flow_migration_ctrl
    import flow_mig_pkg::*;
#(
    parameter int NUM_PORTS   = 8,
    parameter int HASH_WIDTH  = 10,
    parameter int TUPLE_WIDTH = 104,
    parameter int TIME_WIDTH  = 32
)(
    input  logic                   axis_aclk,
    input  logic                   axis_resetn,
    input  logic                   meta_valid,
    output logic                   meta_ready,
    input  logic [TUPLE_WIDTH-1:0] meta_tuple,
    input  logic [HASH_WIDTH-1:0]  meta_hash,
    input  logic                   meta_fin,
    input  logic [NUM_PORTS-1:0]   meta_port,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic                   dec_buffer,
    output logic                   dec_collision,
    input  logic                   migration_progress,
    input  logic [1:0]             buffering_type,
    input  logic [NUM_PORTS-1:0]   buffering_port,
    input  logic [TIME_WIDTH-1:0]  timeout_cycles,
    input  logic                   release_done,
    output logic                   migration_ready,
    output logic                   releasing,
    output logic                   busy_init,
    output logic [15:0]            collision_count
);

    localparam int EW = entry_width(TUPLE_WIDTH, TIME_WIDTH);
    localparam int EB = epoch_bit(TUPLE_WIDTH, TIME_WIDTH);
    localparam int FB = fin_bit(TUPLE_WIDTH, TIME_WIDTH);
    localparam int VB = valid_bit(TUPLE_WIDTH, TIME_WIDTH);
    localparam logic [HASH_WIDTH-1:0] ADDR_MAX = '1;

    state_t                 state, state_nx;
    logic [TIME_WIDTH-1:0]  now;
    logic [HASH_WIDTH-1:0]  addr;
    logic                   clean;
    logic                   scan_rd;
    logic                   s1_valid;
    logic [TUPLE_WIDTH-1:0] s1_tuple;
    logic [HASH_WIDTH-1:0]  s1_hash;
    logic                   s1_fin;
    logic [NUM_PORTS-1:0]   s1_port;
    logic [HASH_WIDTH-1:0]  rd_addr, rd_addr_q, wr_addr, fwd_addr;
    logic [EW-1:0]          rd_data, fwd_data, wr_data, cur;
    logic                   fwd_valid, wr_en;
    logic                   stall, accept, s1_fire, scan_issue;
    logic                   stale, hit, collision, new_epoch, pm, dec_buffer_nx;
    logic                   old_live, pass_end;

    assign stall      = dec_valid & ~dec_ready & s1_valid;
    assign meta_ready = ~stall & (state != ST_INIT);
    assign accept     = meta_valid & meta_ready;
    assign s1_fire    = s1_valid & ~stall;
    assign scan_issue = (state == ST_SCAN) & ~accept & ~stall;
    assign rd_addr    = stall ? s1_hash : accept ? meta_hash : addr;

    // Lookup against the entry read last cycle, bypassing a write that raced the read
    always_comb begin
        cur           = (fwd_valid && fwd_addr == rd_addr_q) ? fwd_data : rd_data;
        stale         = ~cur[VB] | cur[FB] | ((now - cur[EB-1:TUPLE_WIDTH]) > timeout_cycles);
        hit           = cur[VB] & (cur[TUPLE_WIDTH-1:0] == s1_tuple);
        collision     = ~hit & ~stale;
        new_epoch     = hit ? cur[EB] : (state != ST_IDLE);
        pm            = |(s1_port & buffering_port);
        dec_buffer_nx = (state == ST_SCAN) ? pm & (new_epoch | collision) :
                        (state == ST_MIGRATE || state == ST_RELEASE) & pm;
        old_live      = scan_rd & cur[VB] & ~stale & ~cur[EB];
        pass_end      = scan_rd & (rd_addr_q == ADDR_MAX);
        wr_en         = (state == ST_INIT) | (s1_fire & ~collision);
        wr_addr       = (state == ST_INIT) ? addr : s1_hash;
        wr_data       = (state == ST_INIT) ? '0 : {1'b1, s1_fin, new_epoch, now, s1_tuple};
    end

    flow_table_ram #(.AW(HASH_WIDTH), .DW(EW)) u_ram (
        .axis_aclk (axis_aclk),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    // Next state and mode outputs
    always_comb begin
        state_nx        = state;
        migration_ready = (state == ST_MIGRATE);
        releasing       = (state == ST_RELEASE);
        busy_init       = (state == ST_INIT);
        unique case (state)
            ST_INIT:    if (addr == ADDR_MAX) state_nx = ST_IDLE;
            ST_IDLE:    if (migration_progress)
                            state_nx = (buffering_type == BUF_STREAM) ? ST_SCAN :
                                       (buffering_type == BUF_NONE) ? ST_IDLE : ST_MIGRATE;
            ST_SCAN:    if (!migration_progress) state_nx = ST_IDLE;
                        else if (pass_end && clean && !old_live) state_nx = ST_MIGRATE;
            ST_MIGRATE: if (!migration_progress) state_nx = ST_RELEASE;
            ST_RELEASE: if (release_done) state_nx = ST_IDLE;
            default:    state_nx = ST_INIT;
        endcase
    end

    // State, timer, init/scan pointer and pass-clean tracking
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state   <= ST_INIT;
            now     <= '0;
            addr    <= '0;
            clean   <= 1'b1;
            scan_rd <= 1'b0;
        end else begin
            state   <= state_nx;
            now     <= now + 1'b1;
            scan_rd <= scan_issue;
            if (state == ST_INIT || scan_issue) addr <= addr + 1'b1;
            else if (state != ST_SCAN) addr <= '0;
            if (state != ST_SCAN || pass_end) clean <= 1'b1;
            else if (old_live) clean <= 1'b0;
        end
    end

    // S0->S1 capture, held while the decision slot is blocked
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            s1_valid  <= 1'b0;
            fwd_valid <= 1'b0;
        end else begin
            fwd_valid <= wr_en;
            if (!stall) s1_valid <= accept;
        end
    end

    // Datapath registers: S1 metadata, read address and bypass copy of the last write
    always_ff @(posedge axis_aclk) begin
        rd_addr_q <= rd_addr;
        fwd_addr  <= wr_addr;
        fwd_data  <= wr_data;
        if (accept) begin
            s1_tuple <= meta_tuple;
            s1_hash  <= meta_hash;
            s1_fin   <= meta_fin;
            s1_port  <= meta_port;
        end
    end

    // S2 decision register and saturating collision counter
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            dec_valid       <= 1'b0;
            dec_buffer      <= 1'b0;
            dec_collision   <= 1'b0;
            collision_count <= '0;
        end else if (s1_fire) begin
            dec_valid     <= 1'b1;
            dec_buffer    <= dec_buffer_nx;
            dec_collision <= collision;
            if (collision && collision_count != 16'hFFFF) collision_count <= collision_count + 16'd1;
        end else if (dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flow_migration_ctrl.sv
// tb_flow_migration_ctrl: directed tests against a flow-table model with per-decision scoreboard
module tb_flow_migration_ctrl;

    localparam int NP = 8, HW = 4, TUW = 104, TMW = 32;
    localparam int M_IDLE = 0, M_SCAN = 1, M_MIG = 2, M_REL = 3;

    logic           axis_aclk = 0, axis_resetn = 0;
    logic           meta_valid, meta_ready, meta_fin;
    logic [TUW-1:0] meta_tuple;
    logic [HW-1:0]  meta_hash;
    logic [NP-1:0]  meta_port, buffering_port;
    logic           dec_valid, dec_ready, dec_buffer, dec_collision;
    logic           migration_progress, release_done;
    logic [1:0]     buffering_type;
    logic [TMW-1:0] timeout_cycles;
    logic           migration_ready, releasing, busy_init;
    logic [15:0]    collision_count;

    always #5 axis_aclk = ~axis_aclk;

    flow_migration_ctrl #(.NUM_PORTS(NP), .HASH_WIDTH(HW), .TUPLE_WIDTH(TUW), .TIME_WIDTH(TMW)) dut (
        .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
        .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_tuple(meta_tuple),
        .meta_hash(meta_hash), .meta_fin(meta_fin), .meta_port(meta_port),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_buffer(dec_buffer),
        .dec_collision(dec_collision), .migration_progress(migration_progress),
        .buffering_type(buffering_type), .buffering_port(buffering_port),
        .timeout_cycles(timeout_cycles), .release_done(release_done),
        .migration_ready(migration_ready), .releasing(releasing),
        .busy_init(busy_init), .collision_count(collision_count)
    );

    typedef struct {bit v; bit f; bit e; logic [31:0] t; logic [TUW-1:0] tup;} ment_t;
    typedef struct {bit b; bit c; int cnt;} exp_t;

    ment_t       tbl [16];
    exp_t        q [$];
    bit          hist_b [$];
    bit          hist_c [$];
    int          mode, mcnt, checks, passes, h0;
    logic [31:0] cyc;

    localparam logic [TUW-1:0] TA = 104'hA0A0_0001, TB = 104'hB0B0_0002, TC = 104'hC0C0_0003;
    localparam logic [TUW-1:0] TE = 104'hE0E0_0005, TF = 104'hF0F0_0006;
    logic [TUW-1:0] st_tup [6] = '{104'h11, 104'h12, 104'h13, 104'h19, 104'h14, 104'h15};
    logic [HW-1:0]  st_h   [6] = '{4'd11, 4'd12, 4'd13, 4'd9, 4'd14, 4'd15};
    logic [NP-1:0]  st_p   [6] = '{8'h04, 8'h02, 8'h04, 8'h04, 8'h02, 8'h04};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Cycle count since reset release, the reference for flow ages
    always @(posedge axis_aclk or negedge axis_resetn)
        if (!axis_resetn) cyc <= 0;
        else cyc <= cyc + 1;

    // Model of one accepted packet, looked up the cycle after acceptance
    task automatic model_accept();
        logic [31:0] now;
        ment_t e;
        bit stale, hit, col, ep, pm;
        exp_t x;
        now   = cyc + 1;
        e     = tbl[meta_hash];
        stale = !e.v || e.f || ((now - e.t) > timeout_cycles);
        hit   = e.v && (e.tup == meta_tuple);
        col   = !hit && !stale;
        ep    = hit ? e.e : (mode != M_IDLE);
        pm    = |(meta_port & buffering_port);
        if (!col) tbl[meta_hash] = '{1'b1, meta_fin, ep, now, meta_tuple};
        if (col && mcnt < 65535) mcnt++;
        x.b   = (mode == M_SCAN) ? (pm && (ep || col)) : (mode == M_MIG || mode == M_REL) ? pm : 1'b0;
        x.c   = col;
        x.cnt = mcnt;
        q.push_back(x);
    endtask

    // Scoreboard: every consumed decision against the model, in order
    always @(negedge axis_aclk) begin : cmp
        exp_t x;
        if (axis_resetn) begin
            if (dec_valid && dec_ready) begin
                if (q.size() == 0) chk("dec_spurious", 1, 0);
                else begin
                    x = q.pop_front();
                    chk("dec_buffer", dec_buffer, x.b);
                    chk("dec_collision", dec_collision, x.c);
                    chk("collision_count", collision_count, x.cnt);
                    hist_b.push_back(dec_buffer);
                    hist_c.push_back(dec_collision);
                end
            end
            if (meta_valid && meta_ready) model_accept();
        end
    end

    task automatic reset_dut();
        int n;
        bit ready_seen;
        axis_resetn = 0;
        for (int i = 0; i < 16; i++) tbl[i] = '{default: 0};
        q.delete();
        mcnt = 0;
        mode = M_IDLE;
        repeat (2) @(posedge axis_aclk);
        @(negedge axis_aclk);
        chk("rst_busy_init", busy_init, 1);
        chk("rst_meta_ready", meta_ready, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_migration_ready", migration_ready, 0);
        chk("rst_releasing", releasing, 0);
        chk("rst_collision_count", collision_count, 0);
        @(posedge axis_aclk);
        #1 axis_resetn = 1;
        n = 0;
        ready_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge axis_aclk);
            if (!busy_init) break;
            if (meta_ready) ready_seen = 1;
            n++;
        end
        chk("init_cycles", n, 16);
        chk("init_meta_ready_low", ready_seen, 0);
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic send(input logic [TUW-1:0] tup, input logic [HW-1:0] h, input bit fin, input logic [NP-1:0] port);
        bit ok;
        ok = 0;
        meta_tuple = tup;
        meta_hash  = h;
        meta_fin   = fin;
        meta_port  = port;
        meta_valid = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge axis_aclk);
            if (meta_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge axis_aclk);
        #1 meta_valid = 0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge axis_aclk);
            if (q.size() == 0 && !dec_valid) begin
                ok = 1;
                break;
            end
        end
        chk("drain", ok, 1);
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic wait_mr(input int lim);
        bit ok;
        ok = 0;
        for (int n = 0; n < lim; n++) begin
            @(negedge axis_aclk);
            if (migration_ready) begin
                ok = 1;
                break;
            end
        end
        chk("migrate_reached", ok, 1);
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic lit(input string name, input int idx, input bit b, input bit c);
        chk({name, "_buf"}, (idx < hist_b.size()) ? hist_b[idx] : 1'bx, b);
        chk({name, "_col"}, (idx < hist_c.size()) ? hist_c[idx] : 1'bx, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        meta_valid = 0; meta_tuple = '0; meta_hash = '0; meta_fin = 0; meta_port = '0;
        dec_ready = 1; migration_progress = 0; buffering_type = 2'd0; buffering_port = 8'hFF;
        timeout_cycles = 1000; release_done = 0;
        checks = 0; passes = 0;
        reset_dut();
        chk("idle_busy_init", busy_init, 0);
        chk("idle_migration_ready", migration_ready, 0);
        chk("idle_releasing", releasing, 0);
        chk("idle_dec_valid", dec_valid, 0);
        chk("idle_meta_ready", meta_ready, 1);

        // Same flow back-to-back, then a foreign flow on the same hash
        h0 = hist_b.size();
        send(TA, 4'd3, 0, 8'h01);
        send(TA, 4'd3, 0, 8'h01);
        send(TC, 4'd3, 0, 8'h01);
        drain();
        lit("idle_a1", h0, 0, 0);
        lit("idle_a2", h0 + 1, 0, 0);
        lit("idle_c", h0 + 2, 0, 1);
        chk("idle_collision_count", collision_count, 1);

        // Stream mode: old flow A stays unbuffered, new flow B is buffered
        buffering_type = 2'd3;
        migration_progress = 1;
        mode = M_SCAN;
        repeat (2) @(posedge axis_aclk);
        #1;
        h0 = hist_b.size();
        send(TB, 4'd5, 0, 8'h01);
        send(TA, 4'd3, 0, 8'h01);
        drain();
        lit("scan_b", h0, 1, 0);
        lit("scan_a", h0 + 1, 0, 0);
        repeat (60) @(posedge axis_aclk);
        #1 chk("scan_held_by_live_a", migration_ready, 0);
        send(TA, 4'd3, 1, 8'h01);
        drain();
        lit("scan_a_fin", h0 + 2, 0, 0);
        wait_mr(200);
        mode = M_MIG;
        migration_progress = 0;
        mode = M_REL;
        @(posedge axis_aclk);
        #1;
        @(negedge axis_aclk);
        chk("release_releasing", releasing, 1);
        chk("release_migration_ready", migration_ready, 0);
        release_done = 1;
        @(posedge axis_aclk);
        #1 release_done = 0;
        mode = M_IDLE;
        @(negedge axis_aclk);
        chk("release_done_idle", releasing, 0);

        // Stream mode where old flow A ages out instead of sending FIN
        timeout_cycles = 50;
        send(TA, 4'd3, 0, 8'h01);
        drain();
        migration_progress = 1;
        mode = M_SCAN;
        repeat (30) @(posedge axis_aclk);
        #1 chk("timeout_not_yet", migration_ready, 0);
        wait_mr(200);
        mode = M_MIG;
        migration_progress = 0;
        @(posedge axis_aclk);
        #1;
        mode = M_REL;
        // Release completes while a new request is already up: IDLE first, MIGRATE next cycle
        buffering_type = 2'd1;
        migration_progress = 1;
        release_done = 1;
        @(posedge axis_aclk);
        #1 release_done = 0;
        @(negedge axis_aclk);
        chk("simul_idle_releasing", releasing, 0);
        chk("simul_idle_migration_ready", migration_ready, 0);
        @(negedge axis_aclk);
        chk("simul_then_migrate", migration_ready, 1);
        mode = M_MIG;
        @(posedge axis_aclk);
        #1;

        // Buffer-all mode honours the port mask
        buffering_port = 8'h04;
        h0 = hist_b.size();
        send(TE, 4'd9, 0, 8'h04);
        send(TF, 4'd10, 0, 8'h02);
        drain();
        lit("mig_port4", h0, 1, 0);
        lit("mig_port2", h0 + 1, 0, 0);

        // Decision consumer stalls for five cycles under a continuous stream
        timeout_cycles = 1000;
        h0 = hist_b.size();
        dec_ready = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(st_tup[i], st_h[i], 0, st_p[i]);
            end
            begin
                repeat (4) @(posedge axis_aclk);
                @(negedge axis_aclk);
                chk("stall_meta_ready", meta_ready, 0);
                @(posedge axis_aclk);
                #1 dec_ready = 1;
            end
        join
        drain();
        lit("stall0", h0, 1, 0);
        lit("stall1", h0 + 1, 0, 0);
        lit("stall2", h0 + 2, 1, 0);
        lit("stall3", h0 + 3, 1, 1);
        lit("stall4", h0 + 4, 0, 0);
        lit("stall5", h0 + 5, 1, 0);
        chk("stall_collision_count", collision_count, 2);

        // Reset in MIGRATE reclears the table: C no longer collides with A
        migration_progress = 0;
        reset_dut();
        chk("rereset_migration_ready", migration_ready, 0);
        h0 = hist_b.size();
        send(TC, 4'd3, 0, 8'h01);
        drain();
        lit("rereset_c", h0, 0, 0);
        chk("rereset_collision_count", collision_count, 0);
        chk("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
